rgb2ycbcr: RTL and testbench

RGB2YCBCR -- requirements
Module: rgb2ycbcr

---
 rtl/isp_pkg.sv | 48 ++++
 rtl/rgb2ycbcr_if.sv | 37 +++
 rtl/ycbcr_dot3.sv | 43 ++++
 rtl/rgb2ycbcr.sv | 220 ++++++++++++++++++++++
 tb/tb_rgb2ycbcr.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/isp_pkg.sv
// Shared ISP definitions: sample width, channel tags, colour-space coefficients and FSM encodings.
package isp_pkg;

  localparam int unsigned COLOR_DEPTH = 8;
  localparam int unsigned TagW        = 3;
  localparam int unsigned CoefW       = 9;
  localparam int unsigned AccW        = 18;
  localparam int unsigned FracBits    = 8;

  typedef logic [TagW-1:0]         tag_t;
  typedef logic signed [CoefW-1:0] coef_t;
  typedef logic signed [AccW-1:0]  acc_t;

  // Input channel tags
  localparam tag_t TagRed   = 3'd0;
  localparam tag_t TagGreen = 3'd1;
  localparam tag_t TagBlue  = 3'd2;
  localparam tag_t TagVoid  = 3'd3;
  // Output channel tags
  localparam tag_t TagY     = 3'd0;
  localparam tag_t TagCb    = 3'd1;
  localparam tag_t TagCr    = 3'd2;

  localparam coef_t CoefYR  = 9'sd77;
  localparam coef_t CoefYG  = 9'sd150;
  localparam coef_t CoefYB  = 9'sd29;
  localparam coef_t CoefCbR = -9'sd43;
  localparam coef_t CoefCbG = -9'sd85;
  localparam coef_t CoefCbB = 9'sd128;
  localparam coef_t CoefCrR = 9'sd128;
  localparam coef_t CoefCrG = -9'sd107;
  localparam coef_t CoefCrB = -9'sd21;

  localparam acc_t OffLuma   = 18'sd0;
  localparam acc_t OffChroma = 18'sd128;

  typedef enum logic [1:0] {StWaitR, StWaitG, StWaitB} asm_state_e;
  typedef enum logic [1:0] {BtIdle, BtCb, BtCr} beat_e;

  function automatic tag_t expected_tag(asm_state_e st);
    case (st)
      StWaitG: return TagGreen;
      StWaitB: return TagBlue;
      default: return TagRed;
    endcase
  endfunction

endpackage

// File: rtl/rgb2ycbcr_if.sv
// Sample stream bundle for rgb2ycbcr; bypass_in exists only with RGB2YCBCR_BYPASS_EN defined.
interface rgb2ycbcr_if;
  import isp_pkg::*;

  logic [COLOR_DEPTH-1:0] pixel_in;
  logic                   valid_in;
  tag_t                   color_in;
  logic                   last_col_in;
  logic                   last_pic_in;
`ifdef RGB2YCBCR_BYPASS_EN
  logic                   bypass_in;
`endif

  logic [COLOR_DEPTH-1:0] pixel_out;
  logic                   valid_out;
  tag_t                   color_out;
  logic                   last_col_out;
  logic                   last_pic_out;
  logic                   seq_err;

  modport master (
    output pixel_in, valid_in, color_in, last_col_in, last_pic_in,
`ifdef RGB2YCBCR_BYPASS_EN
    output bypass_in,
`endif
    input  pixel_out, valid_out, color_out, last_col_out, last_pic_out, seq_err
  );

  modport slave (
    input  pixel_in, valid_in, color_in, last_col_in, last_pic_in,
`ifdef RGB2YCBCR_BYPASS_EN
    input  bypass_in,
`endif
    output pixel_out, valid_out, color_out, last_col_out, last_pic_out, seq_err
  );

endinterface

// File: rtl/ycbcr_dot3.sv
// Three-term signed dot product with rounding, floor shift, offset and clamp to pixel range.
module ycbcr_dot3
  import isp_pkg::*;
(
  input  coef_t                  coef_a_i,
  input  coef_t                  coef_b_i,
  input  coef_t                  coef_c_i,
  input  logic [COLOR_DEPTH-1:0] s_a_i,
  input  logic [COLOR_DEPTH-1:0] s_b_i,
  input  logic [COLOR_DEPTH-1:0] s_c_i,
  input  acc_t                   offset_i,
  output logic [COLOR_DEPTH-1:0] result_o
);

  localparam acc_t RoundK = 18'sd128;
  localparam acc_t MaxPix = 18'sd255;

  acc_t ca, cb, cc;
  acc_t sa, sb, sc;
  acc_t acc, scaled;

  assign ca = AccW'(coef_a_i);
  assign cb = AccW'(coef_b_i);
  assign cc = AccW'(coef_c_i);
  assign sa = {{(AccW-COLOR_DEPTH){1'b0}}, s_a_i};
  assign sb = {{(AccW-COLOR_DEPTH){1'b0}}, s_b_i};
  assign sc = {{(AccW-COLOR_DEPTH){1'b0}}, s_c_i};

  assign acc    = ca * sa + cb * sb + cc * sc + RoundK;
  // Arithmetic shift floors negative chroma sums before the offset is applied
  assign scaled = (acc >>> FracBits) + offset_i;

  always_comb begin
    if (scaled[AccW-1]) begin
      result_o = '0;
    end else if (scaled > MaxPix) begin
      result_o = '1;
    end else begin
      result_o = scaled[COLOR_DEPTH-1:0];
    end
  end

endmodule

// File: rtl/rgb2ycbcr.sv
// Assembles R,G,B sample triplets and emits Y,Cb,Cr beats; RGB2YCBCR_BYPASS_EN adds a pass-through.
module rgb2ycbcr
  import isp_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  rgb2ycbcr_if.slave bus
);

  // Input register stage
  logic [COLOR_DEPTH-1:0] pix_q;
  logic                   vld_q;
  tag_t                   tag_q;
  logic                   lc_q, lp_q, byp_q;
  logic                   byp_in;

`ifdef RGB2YCBCR_BYPASS_EN
  assign byp_in = bus.bypass_in;
`else
  assign byp_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
      vld_q <= 1'b0;
      tag_q <= TagVoid;
      lc_q  <= 1'b0;
      lp_q  <= 1'b0;
      byp_q <= 1'b0;
    end else begin
      pix_q <= bus.pixel_in;
      vld_q <= bus.valid_in;
      tag_q <= bus.color_in;
      lc_q  <= bus.last_col_in;
      lp_q  <= bus.last_pic_in;
      byp_q <= byp_in;
    end
  end

  // Triplet assembly
  asm_state_e             state_q;
  logic [COLOR_DEPTH-1:0] r_q, g_q;
  logic                   lc_acc_q, lp_acc_q, byp_acc_q;
  logic                   trip_vld_q;
  logic [COLOR_DEPTH-1:0] trip_r_q, trip_g_q, trip_b_q;
  logic                   trip_lc_q, trip_lp_q, trip_byp_q;
  logic                   seq_err_q;
  logic                   tag_ok;

  assign tag_ok = (tag_q == expected_tag(state_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitR;
      r_q        <= '0;
      g_q        <= '0;
      lc_acc_q   <= 1'b0;
      lp_acc_q   <= 1'b0;
      byp_acc_q  <= 1'b0;
      trip_vld_q <= 1'b0;
      trip_r_q   <= '0;
      trip_g_q   <= '0;
      trip_b_q   <= '0;
      trip_lc_q  <= 1'b0;
      trip_lp_q  <= 1'b0;
      trip_byp_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      trip_vld_q <= 1'b0;
      if (vld_q && tag_ok) begin
        case (state_q)
          StWaitR: begin
            r_q       <= pix_q;
            lc_acc_q  <= lc_q;
            lp_acc_q  <= lp_q;
            byp_acc_q <= byp_q;
            state_q   <= StWaitG;
          end
          StWaitG: begin
            g_q      <= pix_q;
            lc_acc_q <= lc_acc_q | lc_q;
            lp_acc_q <= lp_acc_q | lp_q;
            state_q  <= StWaitB;
          end
          StWaitB: begin
            trip_vld_q <= 1'b1;
            trip_r_q   <= r_q;
            trip_g_q   <= g_q;
            trip_b_q   <= pix_q;
            trip_lc_q  <= lc_acc_q | lc_q;
            trip_lp_q  <= lp_acc_q | lp_q;
            trip_byp_q <= byp_acc_q;
            lc_acc_q   <= 1'b0;
            lp_acc_q   <= 1'b0;
            state_q    <= StWaitR;
          end
          default: state_q <= StWaitR;
        endcase
      end else if (vld_q) begin
        // Out-of-order tag: drop the partial triplet, but a RED restarts assembly
        seq_err_q <= 1'b1;
        if (tag_q == TagRed) begin
          r_q       <= pix_q;
          lc_acc_q  <= lc_q;
          lp_acc_q  <= lp_q;
          byp_acc_q <= byp_q;
          state_q   <= StWaitG;
        end else begin
          lc_acc_q <= 1'b0;
          lp_acc_q <= 1'b0;
          state_q  <= StWaitR;
        end
      end
    end
  end

  // Colour conversion
  logic [COLOR_DEPTH-1:0] y_val, cb_val, cr_val;

  ycbcr_dot3 u_dot_y (
    .coef_a_i (CoefYR),
    .coef_b_i (CoefYG),
    .coef_c_i (CoefYB),
    .s_a_i    (trip_r_q),
    .s_b_i    (trip_g_q),
    .s_c_i    (trip_b_q),
    .offset_i (OffLuma),
    .result_o (y_val)
  );

  ycbcr_dot3 u_dot_cb (
    .coef_a_i (CoefCbR),
    .coef_b_i (CoefCbG),
    .coef_c_i (CoefCbB),
    .s_a_i    (trip_r_q),
    .s_b_i    (trip_g_q),
    .s_c_i    (trip_b_q),
    .offset_i (OffChroma),
    .result_o (cb_val)
  );

  ycbcr_dot3 u_dot_cr (
    .coef_a_i (CoefCrR),
    .coef_b_i (CoefCrG),
    .coef_c_i (CoefCrB),
    .s_a_i    (trip_r_q),
    .s_b_i    (trip_g_q),
    .s_c_i    (trip_b_q),
    .offset_i (OffChroma),
    .result_o (cr_val)
  );

  // Beat serialiser: Y now, Cb and Cr held for the next two cycles
  beat_e                  beat_q;
  logic [COLOR_DEPTH-1:0] cb_q, cr_q;
  logic                   hold_lc_q, hold_lp_q, hold_byp_q;
  logic [COLOR_DEPTH-1:0] pix_out_q;
  logic                   vld_out_q, lc_out_q, lp_out_q;
  tag_t                   col_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= BtIdle;
      cb_q       <= '0;
      cr_q       <= '0;
      hold_lc_q  <= 1'b0;
      hold_lp_q  <= 1'b0;
      hold_byp_q <= 1'b0;
      pix_out_q  <= '0;
      vld_out_q  <= 1'b0;
      col_out_q  <= TagVoid;
      lc_out_q   <= 1'b0;
      lp_out_q   <= 1'b0;
    end else begin
      pix_out_q <= '0;
      vld_out_q <= 1'b0;
      col_out_q <= TagVoid;
      lc_out_q  <= 1'b0;
      lp_out_q  <= 1'b0;
      if (trip_vld_q) begin
        pix_out_q  <= trip_byp_q ? trip_r_q : y_val;
        col_out_q  <= trip_byp_q ? TagRed : TagY;
        vld_out_q  <= 1'b1;
        cb_q       <= trip_byp_q ? trip_g_q : cb_val;
        cr_q       <= trip_byp_q ? trip_b_q : cr_val;
        hold_lc_q  <= trip_lc_q;
        hold_lp_q  <= trip_lp_q;
        hold_byp_q <= trip_byp_q;
        beat_q     <= BtCb;
      end else begin
        case (beat_q)
          BtCb: begin
            pix_out_q <= cb_q;
            col_out_q <= hold_byp_q ? TagGreen : TagCb;
            vld_out_q <= 1'b1;
            beat_q    <= BtCr;
          end
          BtCr: begin
            pix_out_q <= cr_q;
            col_out_q <= hold_byp_q ? TagBlue : TagCr;
            vld_out_q <= 1'b1;
            lc_out_q  <= hold_lc_q;
            lp_out_q  <= hold_lp_q;
            beat_q    <= BtIdle;
          end
          default: beat_q <= BtIdle;
        endcase
      end
    end
  end

  assign bus.pixel_out    = pix_out_q;
  assign bus.valid_out    = vld_out_q;
  assign bus.color_out    = col_out_q;
  assign bus.last_col_out = lc_out_q;
  assign bus.last_pic_out = lp_out_q;
  assign bus.seq_err      = seq_err_q;

endmodule

// File: tb/tb_rgb2ycbcr.sv
// Self-checking bench for rgb2ycbcr: table vectors, corner sequences and random stream vs a model.
module tb_rgb2ycbcr;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  rgb2ycbcr_if bus ();

  rgb2ycbcr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef RGB2YCBCR_BYPASS_EN
  initial bus.bypass_in = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] pix;
    logic [2:0] col;
    logic       lc;
    logic       lp;
  } beat_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic [7:0] y, cb, cr;
  } vec_t;

  beat_t      exp_q[$];
  int         part[$];
  logic       acc_lc, acc_lp;
  int         err_cyc;
  bit         use_tbl;
  logic [7:0] tbl_y, tbl_cb, tbl_cr;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic int fl256(int a);
    return (a >= 0) ? a / 256 : -((-a + 255) / 256);
  endfunction

  function automatic logic [7:0] clip(int a);
    if (a < 0) return 8'd0;
    if (a > 255) return 8'd255;
    return 8'(a);
  endfunction

  // Behavioural reference: one call per valid sample at the pins in the current cycle
  function automatic void model_step(logic [7:0] p, logic [2:0] c, logic lc, logic lp);
    int r, g, b;
    logic [7:0] y, cb, cr;
    if (int'(c) == part.size()) begin
      part.push_back(int'(p));
      acc_lc |= lc;
      acc_lp |= lp;
      if (part.size() == 3) begin
        r = part[0]; g = part[1]; b = part[2];
        if (use_tbl) begin
          y = tbl_y; cb = tbl_cb; cr = tbl_cr;
        end else begin
          y  = clip(fl256(77 * r + 150 * g + 29 * b + 128));
          cb = clip(fl256(-43 * r - 85 * g + 128 * b + 128) + 128);
          cr = clip(fl256(128 * r - 107 * g - 21 * b + 128) + 128);
        end
        exp_q.push_back('{cyc + 3, y,  3'd0, 1'b0, 1'b0});
        exp_q.push_back('{cyc + 4, cb, 3'd1, 1'b0, 1'b0});
        exp_q.push_back('{cyc + 5, cr, 3'd2, acc_lc, acc_lp});
        part.delete();
        acc_lc = 1'b0;
        acc_lp = 1'b0;
      end
    end else begin
      if (err_cyc < 0) err_cyc = cyc + 2;
      part.delete();
      acc_lc = 1'b0;
      acc_lp = 1'b0;
      if (c == 3'd0) begin
        part.push_back(int'(p));
        acc_lc = lc;
        acc_lp = lp;
      end
    end
  endfunction

  // Every cycle: either the scheduled beat or the idle pattern, plus the sticky error flag
  always @(negedge clk) begin
    beat_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("beat", {18'd0, bus.valid_out, bus.color_out, bus.pixel_out, bus.last_col_out,
                   bus.last_pic_out}, {18'd0, 1'b1, e.col, e.pix, e.lc, e.lp});
    end else begin
      chk("idle", {18'd0, bus.valid_out, bus.color_out, bus.pixel_out, bus.last_col_out,
                   bus.last_pic_out}, {18'd0, 1'b0, 3'd3, 8'd0, 1'b0, 1'b0});
    end
    chk("seq_err", {31'd0, bus.seq_err}, {31'd0, (err_cyc >= 0 && cyc >= err_cyc)});
  end

  task automatic drive(input logic v, input logic [7:0] p, input logic [2:0] c,
                       input logic lc, input logic lp);
    @(negedge clk);
    #1;
    bus.valid_in    = v;
    bus.pixel_in    = p;
    bus.color_in    = c;
    bus.last_col_in = lc;
    bus.last_pic_in = lp;
    if (v) model_step(p, c, lc, lp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 3'd3, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    exp_q.delete();
    part.delete();
    acc_lc  = 1'b0;
    acc_lp  = 1'b0;
    err_cyc = -1;
    repeat (n) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [2:0] lc_mask, input logic [2:0] lp_mask);
    drive(1'b1, r, 3'd0, lc_mask[0], lp_mask[0]);
    drive(1'b1, g, 3'd1, lc_mask[1], lp_mask[1]);
    drive(1'b1, b, 3'd2, lc_mask[2], lp_mask[2]);
  endtask

  vec_t vecs[4];

  initial begin
    logic       v;
    logic [2:0] c;
    checks   = 0;
    failures = 0;
    err_cyc  = -1;
    acc_lc   = 1'b0;
    acc_lp   = 1'b0;
    use_tbl  = 1'b0;
    rst_n    = 1'b0;
    bus.valid_in    = 1'b0;
    bus.pixel_in    = '0;
    bus.color_in    = 3'd3;
    bus.last_col_in = 1'b0;
    bus.last_pic_in = 1'b0;

    vecs[0] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd128, 8'd128};
    vecs[1] = '{8'd255, 8'd0,   8'd0,   8'd77,  8'd85,  8'd255};
    vecs[2] = '{8'd0,   8'd0,   8'd255, 8'd29,  8'd255, 8'd107};
    vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd128, 8'd128};

    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Known vectors, back-to-back so any gap or lost triplet shows up
    for (int i = 0; i < 4; i++) begin
      use_tbl = 1'b1;
      tbl_y   = vecs[i].y;
      tbl_cb  = vecs[i].cb;
      tbl_cr  = vecs[i].cr;
      send_rgb(vecs[i].r, vecs[i].g, vecs[i].b, 3'b000, 3'b000);
    end
    use_tbl = 1'b0;
    idle(6);

    // Skipped GREEN: no output, sticky error, then recovery
    drive(1'b1, 8'd10, 3'd0, 1'b0, 1'b0);
    drive(1'b1, 8'd20, 3'd2, 1'b0, 1'b0);
    idle(4);
    send_rgb(8'd100, 8'd150, 8'd200, 3'b000, 3'b000);
    idle(6);

    // Flags ORed over the triplet, reported on the Cr beat only
    do_reset(2);
    idle(2);
    send_rgb(8'd30, 8'd60, 8'd90, 3'b010, 3'b000);
    send_rgb(8'd200, 8'd40, 8'd10, 3'b000, 3'b001);
    idle(6);

    // Reset after RED discards it; following G,B alone must not form a triplet
    drive(1'b1, 8'd77, 3'd0, 1'b0, 1'b0);
    do_reset(2);
    idle(4);
    drive(1'b1, 8'd5, 3'd1, 1'b0, 1'b0);
    drive(1'b1, 8'd6, 3'd2, 1'b0, 1'b0);
    idle(4);
    send_rgb(8'd1, 8'd2, 8'd3, 3'b100, 3'b100);
    idle(6);

    // Reset with a complete triplet in flight
    send_rgb(8'd250, 8'd128, 8'd5, 3'b000, 3'b000);
    do_reset(1);
    idle(8);

    // Random stream with gaps and occasional out-of-order tags
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      v = (($urandom % 4) != 0);
      if (($urandom % 12) == 0) c = 3'($urandom % 4);
      else c = 3'(part.size());
      drive(v, 8'($urandom), c, (($urandom % 6) == 0), (($urandom % 11) == 0));
    end
    idle(8);

    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
